// File: rtl/arcade_pause_ctl.sv
// ---------------------------------------------------------------------------
// arcade_pause_ctl
// Merges external pause requests, a user pause toggle and "pause while OSD
// open" into one CPU pause for the game core (clk_sys domain). Pause can be
// held off until the next vertical-blank rising edge (VBL_SYNC=1). Release
// is always immediate.
//
// Optional feature macro: PAUSE_OUTPUT_DIM_EN
//   defined     : dim_video port and idle dim timer present. After
//                 DIM_SECONDS seconds paused with options[1]=1, video is
//                 halved in brightness.
//   not defined : no dim_video port, no timer. rgb_out is simply {r,g,b}
//                 registered once.
//
// SEC_CYCLES is the number of clk_sys cycles per second. It defaults to
// CLKSPEED*1_000_000 and is only overridden to shorten simulations.
// ---------------------------------------------------------------------------
module arcade_pause_ctl #(
   parameter int RW          = 3,
   parameter int GW          = 3,
   parameter int BW          = 2,
   parameter int CLKSPEED    = 18,
   parameter int DIM_SECONDS = 10,
   parameter int NREQ        = 2,
   parameter int VBL_SYNC    = 1,
   parameter int SEC_CYCLES  = CLKSPEED * 1_000_000
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   user_button,
   input  logic [NREQ-1:0]        pause_request,
   input  logic [1:0]             options,
   input  logic                   OSD_STATUS,
   input  logic                   vblank,
   input  logic [RW-1:0]          r,
   input  logic [GW-1:0]          g,
   input  logic [BW-1:0]          b,
   output logic [RW+GW+BW-1:0]    rgb_out,
   output logic                   pause_cpu
`ifdef PAUSE_OUTPUT_DIM_EN
   ,
   output logic                   dim_video
`endif
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ARMED  = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic btn_q;
   logic vblank_q;
   logic toggle;
   logic btn_rise;
   logic vbl_rise;
   logic req;

   // Edge detectors and merged pause request.
   always_comb begin
      btn_rise = user_button & ~btn_q;
      vbl_rise = vblank & ~vblank_q;
      req      = (|pause_request) | toggle | (OSD_STATUS & options[0]);
   end

   // Previous-cycle copies of button and vblank. These deliberately keep
   // tracking during reset so that a button held across reset does not
   // produce a spurious toggle once reset is released.
   always_ff @(posedge clk_sys) begin
      btn_q    <= user_button;
      vblank_q <= vblank;
   end

   // User pause toggle: flips on each button rising edge, cleared by reset.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         toggle <= 1'b0;
      end else if (btn_rise) begin
         toggle <= ~toggle;
      end else begin
         toggle <= toggle;
      end
   end

   // Next-state logic: arm on request, engage on vblank edge, release at once.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (req) begin
               if (VBL_SYNC != 0) begin
                  state_nxt = ST_ARMED;
               end else begin
                  state_nxt = ST_PAUSED;
               end
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_ARMED: begin
            if (!req) begin
               state_nxt = ST_RUN;
            end else if (vbl_rise) begin
               state_nxt = ST_PAUSED;
            end else begin
               state_nxt = ST_ARMED;
            end
         end
         ST_PAUSED: begin
            if (!req) begin
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_PAUSED;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // State register; pause_cpu is registered alongside so it mirrors PAUSED.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= ST_RUN;
         pause_cpu <= 1'b0;
      end else begin
         state     <= state_nxt;
         pause_cpu <= (state_nxt == ST_PAUSED);
      end
   end

`ifdef PAUSE_OUTPUT_DIM_EN
   // ------------------------------------------------------------------------
   // Idle dim timer
   // ------------------------------------------------------------------------
   localparam int PRESC_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
   localparam int SEC_W   = (DIM_SECONDS > 0) ? $clog2(DIM_SECONDS + 1) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SEC_CYCLES - 1);
   localparam logic [SEC_W-1:0]   SEC_LIMIT  = SEC_W'(DIM_SECONDS);

   logic [PRESC_W-1:0] presc;
   logic [SEC_W-1:0]   secs;
   logic [SEC_W-1:0]   secs_nxt;
   logic               timer_run;
   logic               presc_wrap;

   // The timer only advances while staying in PAUSED with dimming enabled;
   // anything else (including the cycle we leave PAUSED) clears it.
   always_comb begin
      timer_run  = (state == ST_PAUSED) & (state_nxt == ST_PAUSED) & options[1];
      presc_wrap = timer_run & (presc == PRESC_LAST);
      if (!timer_run) begin
         secs_nxt = {SEC_W{1'b0}};
      end else if (presc_wrap && (secs != SEC_LIMIT)) begin
         secs_nxt = secs + SEC_W'(1);
      end else begin
         secs_nxt = secs;
      end
   end

   // Prescaler, saturating seconds counter and registered dim flag.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         presc     <= {PRESC_W{1'b0}};
         secs      <= {SEC_W{1'b0}};
         dim_video <= 1'b0;
      end else if (!timer_run) begin
         presc     <= {PRESC_W{1'b0}};
         secs      <= {SEC_W{1'b0}};
         dim_video <= 1'b0;
      end else begin
         if (presc_wrap) begin
            presc <= {PRESC_W{1'b0}};
         end else begin
            presc <= presc + PRESC_W'(1);
         end
         secs      <= secs_nxt;
         dim_video <= (secs_nxt == SEC_LIMIT);
      end
   end

   // ------------------------------------------------------------------------
   // Video path: each channel halves within its own width when dimmed.
   // ------------------------------------------------------------------------
   logic [RW-1:0] r_half;
   logic [GW-1:0] g_half;
   logic [BW-1:0] b_half;

   // Half-brightness versions of the incoming channels.
   always_comb begin
      r_half = r >> 1'b1;
      g_half = g >> 1'b1;
      b_half = b >> 1'b1;
   end

   // Registered RGB output, dimmed while dim_video is set.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rgb_out <= {(RW+GW+BW){1'b0}};
      end else if (dim_video) begin
         rgb_out <= {r_half, g_half, b_half};
      end else begin
         rgb_out <= {r, g, b};
      end
   end
`else
   // Dimming is compiled out; these inputs/settings have no function here.
   logic cfg_unused;

   // Fold otherwise-unreferenced inputs into a single sink signal.
   always_comb begin
      cfg_unused = options[1] ^ DIM_SECONDS[0] ^ SEC_CYCLES[0];
   end

   // Registered RGB pass-through.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rgb_out <= {(RW+GW+BW){1'b0}};
      end else begin
         rgb_out <= {r, g, b};
      end
   end
`endif

endmodule

// File: tb/tb_arcade_pause_ctl.sv
// ---------------------------------------------------------------------------
// tb_arcade_pause_ctl
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural reference model (pause mode + "cycles spent paused
// with dimming enabled"), plus explicit spot checks with fixed constants.
// ---------------------------------------------------------------------------
module tb_arcade_pause_ctl;

   localparam int NREQ = 2;
   localparam int SEC  = 16;   // cycles per "second" in this bench
   localparam int DS   = 2;    // seconds before dimming

`ifdef PAUSE_OUTPUT_DIM_EN
   localparam bit DIM_BUILD = 1'b1;
`else
   localparam bit DIM_BUILD = 1'b0;
`endif

   logic            clk_sys = 1'b0;
   logic            reset;
   logic            user_button;
   logic [NREQ-1:0] pause_request;
   logic [1:0]      options;
   logic            OSD_STATUS;
   logic            vblank;
   logic [2:0]      r;
   logic [2:0]      g;
   logic [1:0]      b;
   logic [7:0]      rgb_out;
   logic            pause_cpu;
`ifdef PAUSE_OUTPUT_DIM_EN
   logic            dim_video;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   int         m_mode    = 0;   // 0 running, 1 waiting for vblank, 2 paused
   bit         m_toggle  = 1'b0;
   bit         m_prev_btn = 1'b0;
   bit         m_prev_vbl = 1'b0;
   int         m_run_len = 0;   // consecutive paused cycles with dimming enabled
   logic       exp_pause = 1'b0;
   logic       exp_dim   = 1'b0;
   logic [7:0] exp_rgb   = 8'd0;

   always #5 clk_sys = ~clk_sys;

   arcade_pause_ctl #(
      .RW(3), .GW(3), .BW(2), .CLKSPEED(1), .DIM_SECONDS(DS),
      .NREQ(NREQ), .VBL_SYNC(1), .SEC_CYCLES(SEC)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .user_button   (user_button),
      .pause_request (pause_request),
      .options       (options),
      .OSD_STATUS    (OSD_STATUS),
      .vblank        (vblank),
      .r             (r),
      .g             (g),
      .b             (b),
      .rgb_out       (rgb_out),
      .pause_cpu     (pause_cpu)
`ifdef PAUSE_OUTPUT_DIM_EN
      ,
      .dim_video     (dim_video)
`endif
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      check("pause_cpu", {7'd0, pause_cpu}, {7'd0, exp_pause});
      check("rgb_out", rgb_out, exp_rgb);
`ifdef PAUSE_OUTPUT_DIM_EN
      check("dim_video", {7'd0, dim_video}, {7'd0, exp_dim});
`endif
   endtask

   // One clock: advance the model with the inputs the DUT samples, then check.
   task automatic tick();
      bit req;
      bit vedge;
      bit was_paused;
      @(posedge clk_sys);
      if (reset) begin
         m_mode    = 0;
         m_toggle  = 1'b0;
         m_run_len = 0;
         exp_rgb   = 8'd0;
      end else begin
         req     = (|pause_request) | m_toggle | (OSD_STATUS & options[0]);
         exp_rgb = exp_dim ? {r / 3'd2, g / 3'd2, b / 2'd2} : {r, g, b};
         vedge   = vblank & ~m_prev_vbl;
         was_paused = (m_mode == 2);
         if (!req)                     m_mode = 0;
         else if (m_mode == 0)         m_mode = 1;
         else if (m_mode == 1 && vedge) m_mode = 2;
         if (was_paused && m_mode == 2 && options[1]) m_run_len++;
         else m_run_len = 0;
         if (user_button && !m_prev_btn) m_toggle = ~m_toggle;
      end
      m_prev_btn = user_button;
      m_prev_vbl = vblank;
      exp_pause  = (m_mode == 2);
      exp_dim    = DIM_BUILD && (m_run_len >= SEC * DS);
      #1;
      check_all();
   endtask

   initial begin
      int first_idx;
      int n;
      bit seen_pause;

      // 1: reset with random inputs
      reset         = 1'b1;
      user_button   = 1'($urandom_range(0, 1));
      pause_request = 2'($urandom_range(0, 3));
      options       = 2'($urandom_range(0, 3));
      OSD_STATUS    = 1'($urandom_range(0, 1));
      vblank        = 1'($urandom_range(0, 1));
      r = 3'($urandom_range(0, 7)); g = 3'($urandom_range(0, 7)); b = 2'($urandom_range(0, 3));
      repeat (3) tick();
      check("reset_pause", {7'd0, pause_cpu}, 8'd0);
      check("reset_rgb", rgb_out, 8'd0);
      reset = 1'b0; user_button = 1'b0; pause_request = 2'b00; options = 2'b00;
      OSD_STATUS = 1'b0; vblank = 1'b0;
      repeat (3) tick();

      // 2: user button held, vblank rises at cycle 20
      first_idx   = -1;
      user_button = 1'b1;
      for (int i = 0; i < 50; i++) begin
         vblank = (i >= 20 && i < 24);
         tick();
         if (pause_cpu === 1'b1 && first_idx < 0) first_idx = i;
      end
      check("t2_entry_cycle", 8'(first_idx), 8'd20);
      user_button = 1'b0; tick();
      user_button = 1'b1; tick();
      user_button = 1'b0; tick();
      check("t2_release", {7'd0, pause_cpu}, 8'd0);

      // 3: short external request with no vblank edge
      seen_pause = 1'b0;
      pause_request = 2'b10;
      repeat (5) begin tick(); if (pause_cpu !== 1'b0) seen_pause = 1'b1; end
      pause_request = 2'b00;
      repeat (3) begin tick(); if (pause_cpu !== 1'b0) seen_pause = 1'b1; end
      check("t3_no_pause", {7'd0, seen_pause}, 8'd0);

      // 4: dimming after DS seconds paused
      options = 2'b10; r = 3'b111; g = 3'b101; b = 2'b11;
      pause_request = 2'b01;
      tick(); tick();
      vblank = 1'b1; tick();
      check("t4_entry", {7'd0, pause_cpu}, 8'd1);
      vblank = 1'b0;
      n = 0;
`ifdef PAUSE_OUTPUT_DIM_EN
      while (dim_video !== 1'b1 && n < 100) begin tick(); n++; end
      check("t4_dim_latency", 8'(n), 8'(SEC * DS));
      tick();
      check("t4_rgb_dim", rgb_out, 8'b011_010_01);
      pause_request = 2'b00; tick();
      check("t4_dim_clear", {7'd0, dim_video}, 8'd0);
`else
      repeat (SEC * DS + 1) tick();
      pause_request = 2'b00; tick();
`endif
      check("t4_unpause", {7'd0, pause_cpu}, 8'd0);
      tick();
      check("t4_rgb_full", rgb_out, 8'b111_101_11);

      // 5: OSD pause gated by options[0]
      options = 2'b00; OSD_STATUS = 1'b1;
      tick(); tick();
      vblank = 1'b1; tick(); vblank = 1'b0; tick();
      check("t5_osd_off", {7'd0, pause_cpu}, 8'd0);
      options = 2'b01; tick(); tick();
      vblank = 1'b1; tick();
      check("t5_osd_on", {7'd0, pause_cpu}, 8'd1);
      vblank = 1'b0; OSD_STATUS = 1'b0; tick(); tick();
      check("t5_osd_release", {7'd0, pause_cpu}, 8'd0);

      // 6: reset while paused and dimmed
      options = 2'b10;
      user_button = 1'b1; tick(); user_button = 1'b0; tick();
      vblank = 1'b1; tick(); vblank = 1'b0;
      repeat (SEC * DS + 2) tick();
`ifdef PAUSE_OUTPUT_DIM_EN
      check("t6_dimmed", {7'd0, dim_video}, 8'd1);
`endif
      reset = 1'b1; tick();
      check("t6_reset_pause", {7'd0, pause_cpu}, 8'd0);
      check("t6_reset_rgb", rgb_out, 8'd0);
      reset = 1'b0; tick();
      vblank = 1'b1; tick(); vblank = 1'b0; tick(); tick();
      check("t6_toggle_cleared", {7'd0, pause_cpu}, 8'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0)  user_button = ~user_button;
         if ($urandom_range(0, 15) == 0) pause_request = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) options = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) OSD_STATUS = ~OSD_STATUS;
         vblank = ((i % 23) < 3);
         r = 3'($urandom_range(0, 7)); g = 3'($urandom_range(0, 7)); b = 2'($urandom_range(0, 3));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
